// File: rtl/sma_fb_inv.sv
// Inverse feedback-form moving average: rebuilds samples from a stream of window sums
// via x[n] = s[n] - s[n-1] + x[n-TAPS], saturating and flagging when the result leaves DW range.
module sma_fb_inv #(
    parameter int DW   = 16,
    parameter int TAPS = 4,
    parameter int SW   = DW + $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 s_valid,
    input  logic signed [SW-1:0] s,
    output logic                 x_valid,
    output logic signed [DW-1:0] x,
    output logic                 err,
    output logic                 state
);

    // state | meaning
    // RUN   | sums reconstruct in range
    // ERR   | a reconstruction saturated; sticky until clr or rst
    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    localparam logic signed [SW+1:0] XMAX = {{(SW+3-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW+1:0] XMIN = {{(SW+3-DW){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        SAT_HI = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        SAT_LO = {1'b1, {(DW-1){1'b0}}};

    state_t             state_q;
    logic [SW-1:0]      s_prev;
    logic [DW-1:0]      h [TAPS];

    logic signed [SW:0]   d;
    logic signed [SW+1:0] h_ext;
    logic signed [SW+1:0] r;
    logic                 ovf_hi;
    logic                 ovf_lo;
    logic [DW-1:0]        x_next;

    always_comb begin
        d      = $signed({s[SW-1], s}) - $signed({s_prev[SW-1], s_prev});
        h_ext  = $signed({{(SW+2-DW){h[TAPS-1][DW-1]}}, h[TAPS-1]});
        r      = $signed({d[SW], d}) + h_ext;
        ovf_hi = (r > XMAX);
        ovf_lo = (r < XMIN);
        x_next = r[DW-1:0];
        if (ovf_hi)
            x_next = SAT_HI;
        else if (ovf_lo)
            x_next = SAT_LO;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            s_prev  <= '0;
            x       <= '0;
            x_valid <= 1'b0;
            err     <= 1'b0;
            for (int k = 0; k < TAPS; k++)
                h[k] <= '0;
        end else if (clr) begin
            state_q <= RUN;
            s_prev  <= '0;
            x       <= '0;
            x_valid <= 1'b0;
            err     <= 1'b0;
            for (int k = 0; k < TAPS; k++)
                h[k] <= '0;
        end else if (s_valid) begin
            s_prev  <= s;
            x       <= x_next;
            x_valid <= 1'b1;
            // History holds the value actually emitted, saturated or not.
            h[0]    <= x_next;
            for (int k = 1; k < TAPS; k++)
                h[k] <= h[k-1];
            if (ovf_hi || ovf_lo) begin
                state_q <= ERR;
                err     <= 1'b1;
            end
        end else begin
            x_valid <= 1'b0;
        end
    end

    assign state = state_q;

endmodule
